// File: rtl/hazard_pkg.sv
// Shared definitions for the five-stage pipeline hazard controller:
// forwarding selects, FSM encoding and the scoreboard slot layout.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WR  = 2'b10;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LD_BUBBLE = 2'b01,
        BR_FLUSH  = 2'b10
    } state_e;

    typedef struct packed {
        logic [4:0] rw;
        logic       reg_wr;
        logic       mem_to_reg;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } slot_t;

    // $0 is hard-wired, so a write to it never produces a hazard.
    function automatic logic slot_match(slot_t s, logic [4:0] r);
        return s.reg_wr && (s.rw == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot shadow of the EX, MEM and WR pipeline registers; the EX slot
// takes an all-zero bubble whenever the ID instruction is held or squashed.
import hazard_pkg::*;

module hazard_scoreboard (
    input  logic  clk,
    input  logic  reset,
    input  slot_t id_slot_i,
    input  logic  bubble_i,
    output slot_t ex_o,
    output slot_t mem_o,
    output slot_t wr_o
);

    slot_t ex_q, mem_q, wr_q;
    slot_t ex_d;

    assign ex_d = bubble_i ? '0 : id_slot_i;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wr_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wr_q  <= mem_q;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wr_o  = wr_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX operand forwarding, one-cycle load-use stall and
// two-slot taken-branch flush, with saturating stall/flush counters.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_rw,
    input  logic             id_reg_wr,
    input  logic             id_mem_to_reg,
    input  logic             ex_taken,
    output logic             stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    slot_t            id_slot, ex_s, mem_s, wr_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use, stall_c, flush_c;
    logic             unused_slot_bits;

    assign id_slot = '{rw: id_rw, reg_wr: id_reg_wr, mem_to_reg: id_mem_to_reg,
                       rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt};

    hazard_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .id_slot_i (id_slot),
        .bubble_i  (stall_c | flush_c),
        .ex_o      (ex_s),
        .mem_o     (mem_s),
        .wr_o      (wr_s)
    );

    // MEM is checked first: it carries the younger of two results for r.
    function automatic logic [1:0] fwd_sel(logic [4:0] r, logic use_r);
        if (use_r && slot_match(mem_s, r)) return FWD_MEM;
        if (use_r && slot_match(wr_s, r))  return FWD_WR;
        return FWD_REG;
    endfunction

    assign fwd_a = fwd_sel(ex_s.rs, ex_s.use_rs);
    assign fwd_b = fwd_sel(ex_s.rt, ex_s.use_rt);

    assign load_use = ex_s.mem_to_reg &&
                      ((id_use_rs && slot_match(ex_s, id_rs)) ||
                       (id_use_rt && slot_match(ex_s, id_rt)));

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        flush_c = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (ex_taken) begin
                        flush_c = 1'b1;
                        state_d = BR_FLUSH;
                    end else if (load_use) begin
                        stall_c = 1'b1;
                        state_d = LD_BUBBLE;
                    end
                end
                LD_BUBBLE: begin
                    if (ex_taken) begin
                        flush_c = 1'b1;
                        state_d = BR_FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end
                BR_FLUSH: state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall      = stall_c;
    assign flush_ifid = flush_c;
    assign flush_idex = flush_c;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

    // Older slots only need their destination fields for forwarding.
    assign unused_slot_bits = ^{mem_s.mem_to_reg, mem_s.rs, mem_s.rt, mem_s.use_rs, mem_s.use_rt,
                                wr_s.mem_to_reg, wr_s.rs, wr_s.rt, wr_s.use_rs, wr_s.use_rt};

endmodule
